// File: rtl/flop_fifo_hs.sv
// Flop-array FIFO with valid/ready handshake, occupancy, watermark and peak tracking.
// Optional same-cycle empty bypass enabled by defining FLOP_FIFO_HS_BYPASS_EN.

module flop_fifo_hs_entry #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // storage is intentionally not reset; out_valid gates its visibility
   always_ff @(posedge clk) begin
      if (we) q <= d;
   end
endmodule

module flop_fifo_hs #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             sync_rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic [CW-1:0]    cfg_watermark,
   output logic [CW-1:0]    count,
   output logic             watermark,
   output logic             half_full,
   output logic [CW-1:0]    max_count,
   input  logic             clr_stats
);
   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH/2);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic [CW-1:0]               cnt_q, cnt_d, max_q, max_d;
   logic                        empty, full;
   logic                        push, pop, push_st, pop_st;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);

   // ready depends only on registered occupancy, never on out_ready
   assign in_ready = !sync_rst && !full;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

`ifdef FLOP_FIFO_HS_BYPASS_EN
   logic bypass;
   // an empty FIFO forwards the producer word straight to the consumer
   assign out_valid = !sync_rst && (!empty || in_valid);
   assign out_data  = empty ? in_data : mem[rd_ptr];
   assign bypass    = empty && in_valid && out_ready;
   assign push_st   = push && !bypass;
   assign pop_st    = pop && !empty;
`else
   assign out_valid = !sync_rst && !empty;
   assign out_data  = mem[rd_ptr];
   assign push_st   = push;
   assign pop_st    = pop;
`endif

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      flop_fifo_hs_entry #(.WIDTH(WIDTH)) u_ent (
         .clk (clk),
         .we  (push_st && (wr_ptr == PW'(i))),
         .d   (in_data),
         .q   (mem[i])
      );
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({push_st, pop_st})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // clear reloads the peak from the post-update occupancy
   always_comb begin
      max_d = max_q;
      if (clr_stats)          max_d = cnt_d;
      else if (cnt_d > max_q) max_d = cnt_d;
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         max_q  <= '0;
      end else begin
         if (push_st) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
         if (pop_st)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
         cnt_q <= cnt_d;
         max_q <= max_d;
      end
   end

   // status is masked during reset so it reads as empty immediately
   assign count     = sync_rst ? '0 : cnt_q;
   assign max_count = sync_rst ? '0 : max_q;
   assign watermark = (count >= cfg_watermark);
   assign half_full = (count >= HALF_CNT);

   a_in_stable: assert property (@(posedge clk) disable iff (sync_rst)
      (in_valid && !in_ready) |=> (in_valid && $stable(in_data)));

endmodule

// File: tb/tb_flop_fifo_hs.sv
// Directed bench for flop_fifo_hs: DEPTH=4 instance for fill/full/stats/reset,
// DEPTH=3 instance for pointer wrap; follows FLOP_FIFO_HS_BYPASS_EN when defined.

module tb_flop_fifo_hs;
   logic       clk = 1'b0;
   logic       rst;
   logic       iv, ordy, clr;
   logic [7:0] idat;
   logic [2:0] cfg;
   logic       irdy, ov, wm, hf;
   logic [7:0] odat;
   logic [2:0] cnt, mx;

   logic       iv3, ordy3;
   logic [7:0] idat3;
   logic       irdy3, ov3, wm3, hf3;
   logic [7:0] odat3;
   logic [1:0] cnt3, mx3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   flop_fifo_hs #(.WIDTH(8), .DEPTH(4)) u_d4 (
      .clk(clk), .sync_rst(rst), .in_valid(iv), .in_data(idat), .in_ready(irdy),
      .out_valid(ov), .out_data(odat), .out_ready(ordy), .cfg_watermark(cfg),
      .count(cnt), .watermark(wm), .half_full(hf), .max_count(mx), .clr_stats(clr)
   );

   flop_fifo_hs #(.WIDTH(8), .DEPTH(3)) u_d3 (
      .clk(clk), .sync_rst(rst), .in_valid(iv3), .in_data(idat3), .in_ready(irdy3),
      .out_valid(ov3), .out_data(odat3), .out_ready(ordy3), .cfg_watermark(2'd0),
      .count(cnt3), .watermark(wm3), .half_full(hf3), .max_count(mx3), .clr_stats(1'b0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   mcnt, nxt, got;
      logic stall, v, r, psh, pp, bp;

      rst = 1; iv = 0; ordy = 0; clr = 0; idat = 0; cfg = 0;
      iv3 = 0; ordy3 = 0; idat3 = 0;
      cyc; cyc;
      check("rst_count", cnt, 0);
      check("rst_ovalid", ov, 0);
      check("rst_irdy", irdy, 0);
      check("rst_wm_cfg0", wm, 1);
      check("rst_half", hf, 0);
      check("rst_max", mx, 0);
      rst = 0; #1;
      check("post_rst_irdy", irdy, 1);

      // fill DEPTH=4
      cfg = 3;
      for (int i = 0; i < 4; i++) begin
         iv = 1; idat = 8'hA1 + 8'(i);
         cyc;
         check("fill_count", cnt, i + 1);
         check("fill_half", hf, (i + 1 >= 2) ? 1 : 0);
         check("fill_wm", wm, (i + 1 >= 3) ? 1 : 0);
      end
      iv = 0; #1;
      check("full_irdy", irdy, 0);
      check("full_max", mx, 4);

      // full with consumer ready: pop happens, push refused, then accepted
      iv = 1; idat = 8'hA5; ordy = 1; #1;
      check("fp_head", odat, 8'hA1);
      check("fp_irdy", irdy, 0);
      cyc;
      check("fp_count3", cnt, 3);
      ordy = 0; #1;
      check("fp_irdy_next", irdy, 1);
      check("fp_head2", odat, 8'hA2);
      cyc;
      check("fp_count4", cnt, 4);
      iv = 0;

      // drain in order
      ordy = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("drain_data", odat, 8'hA2 + 8'(k));
         cyc;
      end
      check("drain_count", cnt, 0);
      cyc;
      check("empty_ordy_count", cnt, 0);
      check("empty_ovalid", ov, 0);
      ordy = 0;

      // watermark and peak
      clr = 1; cyc; clr = 0; #1;
      check("clr_max0", mx, 0);
      iv = 1;
      for (int i = 0; i < 3; i++) begin
         idat = 8'hB1 + 8'(i);
         cyc;
         check("wm_push", wm, (i == 2) ? 1 : 0);
      end
      iv = 0; #1;
      check("peak3", mx, 3);
      ordy = 1;
      cyc;
      check("pop_count2", cnt, 2);
      check("wm_pop1", wm, 0);
      cyc;
      check("pop_count1", cnt, 1);
      check("wm_pop2", wm, 0);
      ordy = 0; #1;
      check("peak_hold", mx, 3);
      clr = 1; cyc; clr = 0; #1;
      check("clr_max1", mx, 1);

      // mid-operation reset at count=2
      iv = 1; idat = 8'hC1; cyc;
      check("mr_count2", cnt, 2);
      rst = 1; iv = 1; idat = 8'hC2; ordy = 1; #1;
      check("mr_hold_count", cnt, 0);
      check("mr_hold_irdy", irdy, 0);
      check("mr_hold_ovalid", ov, 0);
      check("mr_hold_half", hf, 0);
      cyc;
      rst = 0; iv = 0; ordy = 0; #1;
      check("mr_count", cnt, 0);
      check("mr_ovalid", ov, 0);
      check("mr_irdy", irdy, 1);
      check("mr_max", mx, 0);

      // word offered to an empty FIFO with consumer ready
      iv = 1; idat = 8'h5C; ordy = 1; #1;
`ifdef FLOP_FIFO_HS_BYPASS_EN
      check("bp_ovalid", ov, 1);
      check("bp_odata", odat, 8'h5C);
      check("bp_irdy", irdy, 1);
      cyc;
      iv = 0; ordy = 0; #1;
      check("bp_count", cnt, 0);
      check("bp_max", mx, 0);
`else
      check("nbp_ovalid", ov, 0);
      cyc;
      iv = 0; ordy = 0; #1;
      check("nbp_count", cnt, 1);
      check("nbp_ovalid1", ov, 1);
      check("nbp_odata", odat, 8'h5C);
      ordy = 1; cyc; ordy = 0; #1;
      check("nbp_drain", cnt, 0);
`endif
      // empty FIFO, consumer stalled: word is stored
      iv = 1; idat = 8'h3D; #1;
      cyc;
      iv = 0; #1;
      check("st_count", cnt, 1);
      check("st_odata", odat, 8'h3D);
      ordy = 1; cyc; ordy = 0; #1;
      check("st_drain", cnt, 0);

      // wrap on DEPTH=3 against a reference occupancy model
      mcnt = 0; nxt = 0; got = 0; stall = 0;
      for (int c = 0; c < 80 && got < 10; c++) begin
         v = stall || ((nxt < 10) && (c % 3 != 2));
         r = (c % 4) >= 2;
         iv3 = v; idat3 = 8'(nxt); ordy3 = r;
         #1;
         check("wrap_count", cnt3, mcnt);
         bp = 0;
`ifdef FLOP_FIFO_HS_BYPASS_EN
         bp = (mcnt == 0) && v && r;
`endif
         psh = v && (mcnt != 3);
         pp  = r && (mcnt != 0);
         if (bp) begin
            check("wrap_bp_data", odat3, got);
            got++; nxt++;
         end else begin
            if (pp) begin
               check("wrap_data", odat3, got);
               got++;
            end
            if (psh) nxt++;
            mcnt = mcnt + (psh ? 1 : 0) - (pp ? 1 : 0);
         end
         stall = v && !psh;
         cyc;
      end
      iv3 = 0; ordy3 = 0;
      check("wrap_done", got, 10);
      check("wrap_max_le3", (mx3 <= 3) ? 1 : 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
